// File: rtl/conv_tile_feeder.sv
`default_nettype none
// ============================================================================
// Module  : conv_tile_feeder
// Brief   : Loads the weights once, then each output tile's halo window from SRAM for the conv engine.
// Revision: 1.0
// ============================================================================
module conv_tile_feeder #(
    parameter int KX     = 3,
    parameter int PIX    = 3,
    parameter int PIY    = 3,
    parameter int RES    = 8,
    parameter int NIF    = 10,
    parameter int MAP_W  = 12,
    parameter int MAP_H  = 12,
    parameter int ADDR_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    fm_rd_en,
    output logic [ADDR_W-1:0]       fm_rd_addr,
    input  logic [RES-1:0]          fm_rd_data,
    output logic                    wt_rd_en,
    output logic [ADDR_W-1:0]       wt_rd_addr,
    input  logic [RES-1:0]          wt_rd_data,
    output logic [NIF-1:0][PIY+2*(KX/2)-1:0][PIX+(KX/2)-1:0][RES-1:0] pixel_row_array,
    output logic [NIF-1:0][PIY:0][((KX/2) > 0 ? (KX/2) : 1)-1:0][RES-1:0] west_paddings_array,
    output logic [NIF-1:0][KX*KX-1:0][RES-1:0] weights_array,
    output logic                    pixel_ready,
    output logic                    weight_ready,
    input  logic                    accumulator_out_valid,
    output logic                    tile_done,
    output logic                    busy,
    output logic                    done
);

    localparam int H     = KX / 2;
    localparam int WIN_H = PIY + 2 * H;
    localparam int WIN_W = PIX + 2 * H;
    localparam int KK    = KX * KX;
    localparam int TX_N  = MAP_W / PIX;
    localparam int TY_N  = MAP_H / PIY;
    localparam int C_MAX = (KK > WIN_W) ? KK : WIN_W;
    localparam int M_W   = $clog2(NIF + 1);
    localparam int R_W   = $clog2(WIN_H + 1);
    localparam int C_W   = $clog2(C_MAX + 1);
    localparam int TX_W  = $clog2(TX_N + 1);
    localparam int TY_W  = $clog2(TY_N + 1);

    localparam logic [M_W-1:0]    C_M_LAST   = M_W'(NIF - 1);
    localparam logic [R_W-1:0]    C_R_LAST   = R_W'(WIN_H - 1);
    localparam logic [C_W-1:0]    C_WW_LAST  = C_W'(WIN_W - 1);
    localparam logic [C_W-1:0]    C_KK_LAST  = C_W'(KK - 1);
    localparam logic [TX_W-1:0]   C_TX_LAST  = TX_W'(TX_N - 1);
    localparam logic [TY_W-1:0]   C_TY_LAST  = TY_W'(TY_N - 1);
    localparam logic [ADDR_W-1:0] C_H_A      = ADDR_W'(H);
    localparam logic [ADDR_W-1:0] C_XLIM     = ADDR_W'(MAP_W + H);
    localparam logic [ADDR_W-1:0] C_YLIM     = ADDR_W'(MAP_H + H);
    localparam logic [ADDR_W-1:0] C_MAP_W    = ADDR_W'(MAP_W);
    localparam logic [ADDR_W-1:0] C_MAP_SZ   = ADDR_W'(MAP_W * MAP_H);
    localparam logic [ADDR_W-1:0] C_KK_A     = ADDR_W'(KK);
    localparam logic [ADDR_W-1:0] C_PIX_A    = ADDR_W'(PIX);
    localparam logic [ADDR_W-1:0] C_PIY_A    = ADDR_W'(PIY);

    generate
        if ((MAP_W % PIX) != 0 || (MAP_H % PIY) != 0 || (KX % 2) == 0) begin : g_bad_params
            $error("conv_tile_feeder: map size must be a multiple of the tile size and KX must be odd");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD_W  = 3'd1,
        S_LOAD_T  = 3'd2,
        S_PRESENT = 3'd3,
        S_FIN     = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic [M_W-1:0]    r_m;
    logic [R_W-1:0]    r_r;
    logic [C_W-1:0]    r_c;
    logic              r_issue_done;
    logic [TX_W-1:0]   r_tx;
    logic [TY_W-1:0]   r_ty;
    logic [ADDR_W-1:0] r_x0;
    logic [ADDR_W-1:0] r_y0;
    logic              r_tile_done;

    // Read pipeline: slot identity travels one cycle alongside the SRAM access.
    logic              r_pv;
    logic              r_pw;
    logic              r_pzero;
    logic [M_W-1:0]    r_pm;
    logic [R_W-1:0]    r_pr;
    logic [C_W-1:0]    r_pc;

    logic              w_loading;
    logic              w_issue;
    logic              w_last_elem;
    logic              w_last_tile;
    logic              w_in_map;
    logic [ADDR_W-1:0] w_yy;
    logic [ADDR_W-1:0] w_xx;
    logic [ADDR_W-1:0] w_fm_addr;
    logic [ADDR_W-1:0] w_wt_addr;
    logic [RES-1:0]    w_wdata;

    // Window coordinates carry a +H bias so out-of-map tests stay unsigned.
    assign w_yy        = r_y0 + ADDR_W'(r_r);
    assign w_xx        = r_x0 + ADDR_W'(r_c);
    assign w_in_map    = (w_yy >= C_H_A) && (w_yy < C_YLIM) && (w_xx >= C_H_A) && (w_xx < C_XLIM);
    assign w_fm_addr   = ADDR_W'(r_m) * C_MAP_SZ + (w_yy - C_H_A) * C_MAP_W + (w_xx - C_H_A);
    assign w_wt_addr   = ADDR_W'(r_m) * C_KK_A + ADDR_W'(r_c);
    assign w_loading   = (r_state == S_LOAD_W) || (r_state == S_LOAD_T);
    assign w_issue     = w_loading && !r_issue_done;
    assign w_last_elem = (r_state == S_LOAD_W) ? ((r_m == C_M_LAST) && (r_c == C_KK_LAST))
                                               : ((r_m == C_M_LAST) && (r_r == C_R_LAST) && (r_c == C_WW_LAST));
    assign w_last_tile = (r_tx == C_TX_LAST) && (r_ty == C_TY_LAST);
    assign w_wdata     = r_pzero ? '0 : fm_rd_data;

    assign pixel_ready  = (r_state == S_PRESENT);
    assign weight_ready = (r_state == S_PRESENT);
    assign busy         = (r_state != S_IDLE);
    assign done         = (r_state == S_FIN);
    assign tile_done    = r_tile_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        fm_rd_en   = 1'b0;
        fm_rd_addr = '0;
        wt_rd_en   = 1'b0;
        wt_rd_addr = '0;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_LOAD_W;
            end
            S_LOAD_W: begin
                if (w_issue) begin
                    wt_rd_en   = 1'b1;
                    wt_rd_addr = w_wt_addr;
                end
                if (r_issue_done && r_pv) w_next = S_LOAD_T;
            end
            S_LOAD_T: begin
                if (w_issue && w_in_map) begin
                    fm_rd_en   = 1'b1;
                    fm_rd_addr = w_fm_addr;
                end
                if (r_issue_done && r_pv) w_next = S_PRESENT;
            end
            S_PRESENT: begin
                if (accumulator_out_valid) w_next = w_last_tile ? S_FIN : S_LOAD_T;
            end
            S_FIN: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_m          <= '0;
            r_r          <= '0;
            r_c          <= '0;
            r_issue_done <= 1'b0;
            r_tx         <= '0;
            r_ty         <= '0;
            r_x0         <= '0;
            r_y0         <= '0;
            r_tile_done  <= 1'b0;
        end else begin
            r_tile_done <= (r_state == S_PRESENT) && accumulator_out_valid;
            // Every state change starts the element walk afresh.
            if (r_state != w_next) begin
                r_m          <= '0;
                r_r          <= '0;
                r_c          <= '0;
                r_issue_done <= 1'b0;
            end else if (w_issue) begin
                if (w_last_elem) begin
                    r_issue_done <= 1'b1;
                end else if (r_state == S_LOAD_W) begin
                    if (r_c == C_KK_LAST) begin
                        r_c <= '0;
                        r_m <= r_m + 1'b1;
                    end else begin
                        r_c <= r_c + 1'b1;
                    end
                end else begin
                    if (r_c == C_WW_LAST) begin
                        r_c <= '0;
                        if (r_r == C_R_LAST) begin
                            r_r <= '0;
                            r_m <= r_m + 1'b1;
                        end else begin
                            r_r <= r_r + 1'b1;
                        end
                    end else begin
                        r_c <= r_c + 1'b1;
                    end
                end
            end

            if (r_state == S_IDLE && start) begin
                r_tx <= '0;
                r_ty <= '0;
                r_x0 <= '0;
                r_y0 <= '0;
            end else if (r_state == S_PRESENT && accumulator_out_valid && !w_last_tile) begin
                if (r_tx == C_TX_LAST) begin
                    r_tx <= '0;
                    r_x0 <= '0;
                    r_ty <= r_ty + 1'b1;
                    r_y0 <= r_y0 + C_PIY_A;
                end else begin
                    r_tx <= r_tx + 1'b1;
                    r_x0 <= r_x0 + C_PIX_A;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pv    <= 1'b0;
            r_pw    <= 1'b0;
            r_pzero <= 1'b0;
            r_pm    <= '0;
            r_pr    <= '0;
            r_pc    <= '0;
        end else begin
            r_pv    <= w_issue;
            r_pw    <= (r_state == S_LOAD_W);
            r_pzero <= !w_in_map;
            r_pm    <= r_m;
            r_pr    <= r_r;
            r_pc    <= r_c;
        end
    end

    // Window columns 0..H-1 feed the west padding; the rest feed the pixel rows.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pixel_row_array     <= '0;
            west_paddings_array <= '0;
            weights_array       <= '0;
        end else if (r_pv) begin
            if (r_pw) begin
                for (int m = 0; m < NIF; m++) begin
                    for (int k = 0; k < KK; k++) begin
                        if (r_pm == M_W'(m) && r_pc == C_W'(k)) weights_array[m][k] <= wt_rd_data;
                    end
                end
            end else begin
                for (int m = 0; m < NIF; m++) begin
                    for (int r = 0; r < WIN_H; r++) begin
                        for (int cc = 0; cc < PIX + H; cc++) begin
                            if (r_pm == M_W'(m) && r_pr == R_W'(r) && r_pc == C_W'(cc + H))
                                pixel_row_array[m][r][cc] <= w_wdata;
                        end
                    end
                    for (int r = 0; r <= PIY; r++) begin
                        for (int c = 0; c < H; c++) begin
                            if (r_pm == M_W'(m) && r_pr == R_W'(r) && r_pc == C_W'(c))
                                west_paddings_array[m][r][c] <= w_wdata;
                        end
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire
